ofdm_cp_buffer: RTL and testbench

Single-port-RAM controller for the OFDM transmit path that inserts the cyclic prefix. It buffers one time-domain symbol from the IFFT stream into the 1024x16 single-port BRAM (Gowin_SP0). It then replays the last CP_LEN samples followed by the whole symbol on a valid/ready output stream. The block is the RAM's sole master: it drives address, enables and write data, and consumes the RAM's read port.

---
 rtl/ofdm_cp_pkg.sv | 24 ++
 rtl/ofdm_cp_buffer.sv | 178 +++++++++++++++++
 tb/tb_ofdm_cp_buffer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofdm_cp_pkg.sv
// Shared types, default widths and parameter legality helper for the
// OFDM cyclic-prefix buffer.
package ofdm_cp_pkg;

    // Controller phases: one settling cycle, symbol capture, replay issue,
    // and waiting for the final output to be accepted.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } cp_state_t;

    // Defaults matching the 1024x16 single-port BRAM.
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 16;

    // True when the symbol fits the RAM and the prefix is shorter than the symbol.
    function automatic bit cp_params_ok(input int addr_w, input int sym_len, input int cp_len);
        return (sym_len >= 2) && (sym_len <= (1 << addr_w)) &&
               (cp_len >= 1) && (cp_len < sym_len);
    endfunction

endpackage

// File: rtl/ofdm_cp_buffer.sv
// Cyclic-prefix inserter: captures one symbol into the external single-port
// RAM, then replays the last CP_LEN samples followed by the whole symbol.
module ofdm_cp_buffer
    import ofdm_cp_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SYM_LEN = 256,
    parameter int CP_LEN  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_reset,
    output logic              ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    // Read counter spans SYM_LEN+CP_LEN < 2*2**ADDR_W, so one extra bit suffices.
    localparam int CNT_W = ADDR_W + 1;
    localparam int TOTAL = SYM_LEN + CP_LEN;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SYM_LEN - 1);
    localparam logic [ADDR_W-1:0] CP_START  = ADDR_W'(SYM_LEN - CP_LEN);
    localparam logic [CNT_W-1:0]  LAST_RD   = CNT_W'(TOTAL - 1);

    if (!cp_params_ok(ADDR_W, SYM_LEN, CP_LEN)) begin : g_param_check
        $error("ofdm_cp_buffer: illegal SYM_LEN/CP_LEN for ADDR_W");
    end

    cp_state_t         state_r;
    cp_state_t         state_s;
    logic              armed_r;
    logic [ADDR_W-1:0] wr_cnt_r;
    logic [CNT_W-1:0]  rd_cnt_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic              m_valid_r;
    logic              m_last_r;

    logic              s_ready_s;
    logic              in_hs_s;
    logic              advance_s;
    logic              rd_issue_s;
    logic              out_hs_s;
    logic [ADDR_W-1:0] ram_ad_s;
    logic [DATA_W-1:0] ram_din_s;

    assign s_ready   = s_ready_s;
    assign m_valid   = m_valid_r;
    assign m_last    = m_last_r;
    assign m_data    = ram_dout;
    assign ram_oce   = 1'b1;
    assign ram_reset = 1'b0;
    assign ram_wre   = in_hs_s;
    assign ram_ce    = in_hs_s | rd_issue_s;
    assign ram_ad    = ram_ad_s;
    assign ram_din   = ram_din_s;

    // Handshake and read-issue qualifiers derived from the current state.
    always_comb begin
        s_ready_s  = (state_r == ST_FILL);
        in_hs_s    = s_valid && s_ready_s;
        advance_s  = !m_valid_r || m_ready;
        rd_issue_s = (state_r == ST_READ) && advance_s;
        out_hs_s   = m_valid_r && m_ready;
    end

    // RAM address/data mux: write counter while filling, replay pointer while reading.
    always_comb begin
        ram_ad_s  = '0;
        ram_din_s = '0;
        case (state_r)
            ST_FILL: ram_ad_s = wr_cnt_r;
            ST_READ: ram_ad_s = rd_addr_r;
            default: ram_ad_s = '0;
        endcase
        if (in_hs_s) begin
            ram_din_s = s_data;
        end else begin
            ram_din_s = '0;
        end
    end

    // State register; armed_r holds IDLE for one full cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            armed_r <= 1'b0;
        end else begin
            state_r <= state_s;
            armed_r <= 1'b1;
        end
    end

    // Next-state logic for the fill / replay / drain cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (armed_r) state_s = ST_FILL;
                else         state_s = ST_IDLE;
            end
            ST_FILL: begin
                if (in_hs_s && (wr_cnt_r == LAST_ADDR)) state_s = ST_READ;
                else                                     state_s = ST_FILL;
            end
            ST_READ: begin
                if (rd_issue_s && (rd_cnt_r == LAST_RD)) state_s = ST_DRAIN;
                else                                      state_s = ST_READ;
            end
            ST_DRAIN: begin
                // No write may start until the final sample has left ram_dout.
                if (out_hs_s && m_last_r) state_s = ST_FILL;
                else                      state_s = ST_DRAIN;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Write counter and replay pointer; the pointer wraps modulo SYM_LEN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_r  <= '0;
            rd_cnt_r  <= '0;
            rd_addr_r <= '0;
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (in_hs_s) begin
                        if (wr_cnt_r == LAST_ADDR) begin
                            wr_cnt_r  <= '0;
                            rd_cnt_r  <= '0;
                            rd_addr_r <= CP_START;
                        end else begin
                            wr_cnt_r <= wr_cnt_r + 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (rd_issue_s) begin
                        rd_cnt_r <= rd_cnt_r + 1'b1;
                        if (rd_addr_r == LAST_ADDR) rd_addr_r <= '0;
                        else                        rd_addr_r <= rd_addr_r + 1'b1;
                    end
                end
                default: begin
                    wr_cnt_r <= '0;
                end
            endcase
        end
    end

    // Output valid/last track the RAM's one-cycle read latency and hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end else if ((state_r == ST_READ) || (state_r == ST_DRAIN)) begin
            if (advance_s) begin
                m_valid_r <= rd_issue_s;
                m_last_r  <= rd_issue_s && (rd_cnt_r == LAST_RD);
            end
        end else begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ofdm_cp_buffer.sv
// Directed + randomized bench for ofdm_cp_buffer with a behavioural
// 1-cycle-latency single-port RAM and a queue-based reference model.
module tb_ofdm_cp_buffer;

    localparam int AW  = 10;
    localparam int DW  = 16;
    localparam int SYM = 8;
    localparam int CP  = 2;
    localparam int TOT = SYM + CP;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          ram_ce, ram_oce, ram_reset, ram_wre;
    logic [AW-1:0] ram_ad;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;

    ofdm_cp_buffer #(.ADDR_W(AW), .DATA_W(DW), .SYM_LEN(SYM), .CP_LEN(CP)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_reset(ram_reset), .ram_wre(ram_wre),
        .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: normal-mode write also drives the output register.
    logic [DW-1:0] mem [1024];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) begin
                mem[ram_ad] <= ram_din;
                ram_dout    <= ram_din;
            end else begin
                ram_dout <= mem[ram_ad];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Logs of what the DUT did, gathered away from the active edge.
    logic [DW-1:0] out_data_q[$];
    bit            out_last_q[$];
    int            out_cyc_q[$];
    int            in_cyc_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (s_valid && s_ready) in_cyc_q.push_back(cyc);
            if (ram_ce && ram_wre) wr_addr_q.push_back(ram_ad);
            if (m_valid && m_ready) begin
                out_data_q.push_back(m_data);
                out_last_q.push_back(m_last);
                out_cyc_q.push_back(cyc);
            end
            if (s_ready) check("no_output_while_filling", {31'd0, m_valid}, 32'd0);
            if (prev_hold) begin
                check("hold_valid", {31'd0, m_valid}, 32'd1);
                check("hold_data", {16'd0, m_data}, {16'd0, prev_data});
                check("hold_last", {31'd0, m_last}, {31'd0, prev_last});
            end
            prev_hold <= m_valid && !m_ready;
            prev_data <= m_data;
            prev_last <= m_last;
        end else begin
            prev_hold <= 1'b0;
        end
    end

    // Reference model: expected output stream built from the symbols sent.
    logic [DW-1:0] exp_data_q[$];
    bit            exp_last_q[$];

    task automatic add_expected(input logic [DW-1:0] smp [SYM]);
        for (int k = 0; k < TOT; k++) begin
            exp_data_q.push_back(smp[(k + SYM - CP) % SYM]);
            exp_last_q.push_back(k == TOT - 1);
        end
    endtask

    task automatic clear_logs();
        out_data_q.delete(); out_last_q.delete(); out_cyc_q.delete();
        in_cyc_q.delete(); wr_addr_q.delete();
        exp_data_q.delete(); exp_last_q.delete();
    endtask

    task automatic make_seq(input logic [DW-1:0] base, output logic [DW-1:0] smp [SYM]);
        for (int i = 0; i < SYM; i++) smp[i] = base + DW'(i);
    endtask

    task automatic send(input logic [DW-1:0] smp [SYM], input int gap, input bit hold);
        int b;
        for (int i = 0; i < SYM; i++) begin
            s_valid = 1'b1;
            s_data  = smp[i];
            b = 0;
            while (!s_ready && b < 300) begin
                @(posedge clk); #1;
                b++;
            end
            check("send_ready", {31'd0, s_ready}, 32'd1);
            @(posedge clk); #1;
            if (gap > 0 && i < SYM - 1) begin
                s_valid = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
        end
        if (!hold) s_valid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int b = 0;
        while (out_data_q.size() < n && b < 400) begin
            @(posedge clk); #1;
            b++;
        end
        check("output_count", out_data_q.size(), n);
    endtask

    task automatic compare_out(input string tag);
        int n;
        n = (out_data_q.size() < exp_data_q.size()) ? out_data_q.size() : exp_data_q.size();
        check({tag, "_len"}, out_data_q.size(), exp_data_q.size());
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"}, {16'd0, out_data_q[i]}, {16'd0, exp_data_q[i]});
            check({tag, "_last"}, {31'd0, out_last_q[i]}, {31'd0, exp_last_q[i]});
        end
    endtask

    int rdy_mode  = 3;
    int rdy_phase = 0;

    initial begin
        logic [DW-1:0] seq [SYM];
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;

        fork
            forever begin
                @(posedge clk); #1;
                case (rdy_mode)
                    0: m_ready = 1'b1;
                    1: begin
                        m_ready   = (rdy_phase == 0);
                        rdy_phase = (rdy_phase + 1) % 3;
                    end
                    2: m_ready = 1'($urandom_range(0, 1));
                    default: m_ready = 1'b0;
                endcase
            end
        join_none

        // Reset values while rst_n is held low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_last", {31'd0, m_last}, 32'd0);
        check("rst_ram_ce", {31'd0, ram_ce}, 32'd0);
        check("rst_ram_wre", {31'd0, ram_wre}, 32'd0);
        check("rst_ram_ad", {22'd0, ram_ad}, 32'd0);
        check("rst_ram_din", {16'd0, ram_din}, 32'd0);
        check("rst_ram_oce", {31'd0, ram_oce}, 32'd1);
        check("rst_ram_reset", {31'd0, ram_reset}, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("s_ready_after_edge1", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        check("s_ready_after_edge2", {31'd0, s_ready}, 32'd1);
        repeat (3) @(negedge clk);
        check("no_write_without_valid", wr_addr_q.size(), 0);
        @(posedge clk); #1;

        // Back-to-back fill, no backpressure.
        rdy_mode = 0;
        clear_logs();
        make_seq(16'h0010, seq);
        add_expected(seq);
        send(seq, 0, 1'b0);
        wait_out(TOT);
        compare_out("b2b");
        if (out_cyc_q.size() == TOT && in_cyc_q.size() == SYM) begin
            check("first_valid_latency", out_cyc_q[0] - in_cyc_q[SYM-1], 2);
            check("back_to_back_outputs", out_cyc_q[TOT-1] - out_cyc_q[0], TOT - 1);
        end else begin
            check("latency_logs_present", out_cyc_q.size() + in_cyc_q.size(), TOT + SYM);
        end
        repeat (2) @(posedge clk); #1;

        // Same fill with m_ready pattern 1,0,0,...
        rdy_phase = 0;
        rdy_mode  = 1;
        clear_logs();
        add_expected(seq);
        send(seq, 0, 1'b0);
        wait_out(TOT);
        compare_out("toggle");
        repeat (4) @(posedge clk); #1;

        // Gapped input: one sample every third cycle.
        rdy_mode = 0;
        clear_logs();
        add_expected(seq);
        send(seq, 2, 1'b0);
        wait_out(TOT);
        check("gapped_write_count", wr_addr_q.size(), SYM);
        for (int i = 0; i < SYM && i < wr_addr_q.size(); i++)
            check("gapped_write_addr", {22'd0, wr_addr_q[i]}, i);
        compare_out("gapped");
        repeat (2) @(posedge clk); #1;

        // s_valid held high through replay; second symbol must wait.
        clear_logs();
        add_expected(seq);
        send(seq, 0, 1'b1);
        make_seq(16'h0100, seq);
        add_expected(seq);
        send(seq, 0, 1'b0);
        wait_out(2 * TOT);
        compare_out("held_valid");
        if (in_cyc_q.size() == 2 * SYM && out_cyc_q.size() == 2 * TOT)
            check("refill_after_last", in_cyc_q[SYM] - out_cyc_q[TOT-1], 1);
        else
            check("refill_logs_present", in_cyc_q.size(), 2 * SYM);
        repeat (2) @(posedge clk); #1;

        // Random samples, random gaps, random backpressure.
        rdy_mode = 2;
        for (int s = 0; s < 3; s++) begin
            clear_logs();
            for (int i = 0; i < SYM; i++) seq[i] = DW'($urandom);
            add_expected(seq);
            send(seq, $urandom_range(0, 2), 1'b0);
            wait_out(TOT);
            compare_out("random");
            repeat (2) @(posedge clk); #1;
        end

        // Asynchronous reset in the middle of replay.
        rdy_mode = 0;
        clear_logs();
        make_seq(16'h0010, seq);
        send(seq, 0, 1'b0);
        wait_out(5);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("async_rst_m_last", {31'd0, m_last}, 32'd0);
        check("async_rst_ram_ce", {31'd0, ram_ce}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        clear_logs();
        make_seq(16'h0200, seq);
        add_expected(seq);
        send(seq, 0, 1'b0);
        wait_out(TOT);
        compare_out("after_reset");
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
